// File: rtl/if_stage_if.sv
// Signal bundle between the instruction-fetch stage and its neighbours
// (hazard unit, ID-stage decoder/comparator, instruction memory).
// The slave side is the fetch stage itself. The master side is whatever
// drives the control inputs and consumes the IF/ID register.
interface if_stage_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        cmp_out;
  logic [31:0] jr_target;
  logic [31:0] im_rd;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc8;
  logic        ifid_valid;
  logic        fetch_err;

  modport slave (
    input  stall, npc_sel, cmp_out, jr_target, im_rd,
    output pc, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, fetch_err
  );

  modport master (
    output stall, npc_sel, cmp_out, jr_target, im_rd,
    input  pc, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, fetch_err
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with PC register, next-PC selection and IF/ID
// pipeline register. Branches and jumps resolve in ID with one
// architectural delay slot, so nothing is ever flushed. Out-of-range or
// misaligned fetch addresses raise a sticky error flag but do not stop
// the PC from advancing.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input logic       clk,
  input logic       reset,
  if_stage_if.slave bus
);

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  logic [31:0] pc_r;
  logic [31:0] ifid_instr_r;
  logic [31:0] ifid_pc_r;
  logic [31:0] ifid_pc8_r;
  logic        ifid_valid_r;
  logic        fetch_err_r;

  logic [31:0] pc_plus4;
  logic [31:0] ifid_plus4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;
  logic        addr_bad;

  assign pc_plus4   = pc_r + 32'd4;
  assign ifid_plus4 = ifid_pc_r + 32'd4;
  assign branch_off = {{14{ifid_instr_r[15]}}, ifid_instr_r[15:0], 2'b00};
  assign addr_bad   = (pc_r < IM_BASE) || (pc_r > IM_LIMIT) || (pc_r[1:0] != 2'b00);

  // Next-PC mux; an invalid IF/ID entry is a nop, so it always falls through to sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (ifid_valid_r) begin
      case (bus.npc_sel)
        NPC_SEQ:    next_pc = pc_plus4;
        NPC_BRANCH: next_pc = bus.cmp_out ? (ifid_plus4 + branch_off) : pc_plus4;
        NPC_JUMP:   next_pc = {ifid_plus4[31:28], ifid_instr_r[25:0], 2'b00};
        NPC_JR:     next_pc = bus.jr_target;
        default:    next_pc = pc_plus4;
      endcase
    end
  end

  // PC, IF/ID register and sticky fetch error; reset beats stall, stall freezes everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r         <= PC_RESET;
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_pc8_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
      fetch_err_r  <= 1'b0;
    end else if (!bus.stall) begin
      pc_r         <= next_pc;
      ifid_instr_r <= bus.im_rd;
      ifid_pc_r    <= pc_r;
      ifid_pc8_r   <= pc_r + 32'd8;
      ifid_valid_r <= 1'b1;
      fetch_err_r  <= fetch_err_r | addr_bad;
    end
  end

  assign bus.pc         = pc_r;
  assign bus.ifid_instr = ifid_instr_r;
  assign bus.ifid_pc    = ifid_pc_r;
  assign bus.ifid_pc8   = ifid_pc8_r;
  assign bus.ifid_valid = ifid_valid_r;
  assign bus.fetch_err  = fetch_err_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of per-edge input/expected-output
// records replayed in order, plus a hand-written stall/error sequence.
module tb_if_stage;

  localparam logic [31:0] A0 = 32'h2401_0001;
  localparam logic [31:0] A1 = 32'h2402_0002;
  localparam logic [31:0] A2 = 32'h2403_0003;
  localparam logic [31:0] A3 = 32'h2404_0004;
  localparam logic [31:0] BR = 32'h1000_FFFF;
  localparam logic [31:0] JI = 32'h0800_0C40;
  localparam logic [31:0] JR = 32'h03E0_0008;
  localparam logic [31:0] DS = 32'h2405_0005;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  sel;
    logic        cmp;
    logic [31:0] jt;
    logic [31:0] im;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [31:0] e_pc8;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  int   fails;
  vec_t vecs[$];

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic rst, logic stl, logic [1:0] sel, logic cmp,
                              logic [31:0] jt, logic [31:0] im, logic [31:0] e_pc,
                              logic [31:0] e_instr, logic [31:0] e_ipc,
                              logic [31:0] e_pc8, logic e_valid, logic e_err);
    vec_t v;
    v.rst = rst; v.stl = stl; v.sel = sel; v.cmp = cmp; v.jt = jt; v.im = im;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_pc8 = e_pc8;
    v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    bus.stall     = v.stl;
    bus.npc_sel   = v.sel;
    bus.cmp_out   = v.cmp;
    bus.jr_target = v.jt;
    bus.im_rd     = v.im;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " pc"},         bus.pc,                 v.e_pc);
    checkOutput({tag, " ifid_instr"}, bus.ifid_instr,         v.e_instr);
    checkOutput({tag, " ifid_pc"},    bus.ifid_pc,            v.e_ipc);
    checkOutput({tag, " ifid_pc8"},   bus.ifid_pc8,           v.e_pc8);
    checkOutput({tag, " ifid_valid"}, {31'd0, bus.ifid_valid}, {31'd0, v.e_valid});
    checkOutput({tag, " fetch_err"},  {31'd0, bus.fetch_err},  {31'd0, v.e_err});
  endtask

  task automatic stepAndCheck(input string tag, input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkAll(tag, v);
  endtask

  // Table replay, then the hand-written stall/range sequence, then summary.
  initial begin
    checks = 0; passes = 0; fails = 0;
    reset = 1'b0; bus.stall = 1'b0; bus.npc_sel = 2'd0; bus.cmp_out = 1'b0;
    bus.jr_target = 32'h0; bus.im_rd = 32'h0;

    // Three sequential fetches out of reset.
    vecs.push_back(mk(0,0,0,0,0,A0, 32'h3000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,A0, 32'h3004,A0,32'h3000,32'h3008,1,0));
    vecs.push_back(mk(1,0,0,0,0,A1, 32'h3008,A1,32'h3004,32'h300C,1,0));
    vecs.push_back(mk(1,0,0,0,0,A2, 32'h300C,A2,32'h3008,32'h3010,1,0));
    // Taken backward branch at 0x3004: delay slot latched, pc back to 0x3004.
    vecs.push_back(mk(0,0,0,0,0,A0, 32'h3000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,A0, 32'h3004,A0,32'h3000,32'h3008,1,0));
    vecs.push_back(mk(1,0,0,0,0,BR, 32'h3008,BR,32'h3004,32'h300C,1,0));
    vecs.push_back(mk(1,0,1,1,0,A2, 32'h3004,A2,32'h3008,32'h3010,1,0));
    // Same branch not taken.
    vecs.push_back(mk(0,0,0,0,0,A0, 32'h3000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,A0, 32'h3004,A0,32'h3000,32'h3008,1,0));
    vecs.push_back(mk(1,0,0,0,0,BR, 32'h3008,BR,32'h3004,32'h300C,1,0));
    vecs.push_back(mk(1,0,1,0,0,A2, 32'h300C,A2,32'h3008,32'h3010,1,0));
    // j at 0x3010 held by two stall cycles, then redirect to 0x3100.
    vecs.push_back(mk(0,0,0,0,0,A0, 32'h3000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,A0, 32'h3004,A0,32'h3000,32'h3008,1,0));
    vecs.push_back(mk(1,0,0,0,0,A1, 32'h3008,A1,32'h3004,32'h300C,1,0));
    vecs.push_back(mk(1,0,0,0,0,A2, 32'h300C,A2,32'h3008,32'h3010,1,0));
    vecs.push_back(mk(1,0,0,0,0,A3, 32'h3010,A3,32'h300C,32'h3014,1,0));
    vecs.push_back(mk(1,0,0,0,0,JI, 32'h3014,JI,32'h3010,32'h3018,1,0));
    vecs.push_back(mk(1,1,2,0,0,DS, 32'h3014,JI,32'h3010,32'h3018,1,0));
    vecs.push_back(mk(1,1,2,0,0,DS, 32'h3014,JI,32'h3010,32'h3018,1,0));
    vecs.push_back(mk(1,0,2,0,0,DS, 32'h3100,DS,32'h3014,32'h301C,1,0));
    // Misaligned jr target: loaded as-is, error on next edge, sticky until reset.
    vecs.push_back(mk(0,0,0,0,0,A0, 32'h3000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,A0, 32'h3004,A0,32'h3000,32'h3008,1,0));
    vecs.push_back(mk(1,0,0,0,0,JR, 32'h3008,JR,32'h3004,32'h300C,1,0));
    vecs.push_back(mk(1,0,3,0,32'h3002,A2, 32'h3002,A2,32'h3008,32'h3010,1,0));
    vecs.push_back(mk(1,0,0,0,0,A3, 32'h3006,A3,32'h3002,32'h300A,1,1));
    vecs.push_back(mk(1,0,0,0,0,A1, 32'h300A,A1,32'h3006,32'h300E,1,1));
    vecs.push_back(mk(0,0,0,0,0,A1, 32'h3000,0,0,0,0,0));
    // Reset wins over stall and a taken branch in the same cycle.
    vecs.push_back(mk(1,0,0,0,0,A0, 32'h3004,A0,32'h3000,32'h3008,1,0));
    vecs.push_back(mk(1,0,0,0,0,BR, 32'h3008,BR,32'h3004,32'h300C,1,0));
    vecs.push_back(mk(0,1,1,1,0,A2, 32'h3000,0,0,0,0,0));
    // Upper limit 0x6FFC is legal, 0x7000 is not.
    vecs.push_back(mk(1,0,0,0,0,A0, 32'h3004,A0,32'h3000,32'h3008,1,0));
    vecs.push_back(mk(1,0,3,0,32'h6FFC,JR, 32'h6FFC,JR,32'h3004,32'h300C,1,0));
    vecs.push_back(mk(1,0,0,0,0,A2, 32'h7000,A2,32'h6FFC,32'h7004,1,0));
    vecs.push_back(mk(1,0,0,0,0,A3, 32'h7004,A3,32'h7000,32'h7008,1,1));
    // Lower bound: 0x2FFC is just below the legal range.
    vecs.push_back(mk(0,0,0,0,0,A0, 32'h3000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,A0, 32'h3004,A0,32'h3000,32'h3008,1,0));
    vecs.push_back(mk(1,0,3,0,32'h2FFC,JR, 32'h2FFC,JR,32'h3004,32'h300C,1,0));
    vecs.push_back(mk(1,0,0,0,0,A1, 32'h3000,A1,32'h2FFC,32'h3004,1,1));

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      stepAndCheck($sformatf("vec%0d", i), vecs[i]);
    end

    // Out-of-range pc during a stall must not raise the error until the stall clears.
    stepAndCheck("seq reset", mk(0,0,0,0,0,A0, 32'h3000,0,0,0,0,0));
    stepAndCheck("seq fetch", mk(1,0,0,0,0,JR, 32'h3004,JR,32'h3000,32'h3008,1,0));
    stepAndCheck("seq jr",    mk(1,0,3,0,32'h7000,A1, 32'h7000,A1,32'h3004,32'h300C,1,0));
    stepAndCheck("seq stall", mk(1,1,0,0,0,A2, 32'h7000,A1,32'h3004,32'h300C,1,0));
    stepAndCheck("seq stall2",mk(1,1,3,0,32'h4000,A2, 32'h7000,A1,32'h3004,32'h300C,1,0));
    stepAndCheck("seq resume",mk(1,0,0,0,0,A2, 32'h7004,A2,32'h7000,32'h7008,1,1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
